// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the two-requester APB arbiter.
// Imported by apb_rr_pick2 and apb_req_arbiter.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int NUM_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_rr_pick2.sv
// Combinational round-robin pick between two eligible requesters.
// On a tie the requester that was not granted last wins.
module apb_rr_pick2
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic               last_gnt_i,
  output logic               gnt_o,
  output logic               gnt_vld_o
);

  always_comb begin
    gnt_vld_o = |eligible_i;
    if (&eligible_i) begin
      gnt_o = ~last_gnt_i;
    end else begin
      gnt_o = eligible_i[1];
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Serialises req/done commands from two masters onto one APB master port, round-robin.
// Optional ACCESS watchdog enabled by macro APB_REQ_ARBITER_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_CNT_W       = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [APB_ADDR_W-1:0] req_addr0,
  input  logic [APB_ADDR_W-1:0] req_addr1,
  input  logic [APB_DATA_W-1:0] req_wdata0,
  input  logic [APB_DATA_W-1:0] req_wdata1,
  input  logic [APB_STRB_W-1:0] req_wstrb0,
  input  logic [APB_STRB_W-1:0] req_wstrb1,
  output logic [NUM_REQ-1:0]    done,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_STRB_W-1:0] pwstrb,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pslverr,
  input  logic                  pready
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
      (64'd1 << TO_CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("apb_req_arbiter: illegal TIMEOUT_CYCLES/TO_CNT_W combination");
  end

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_STRB_W-1:0] pwstrb_q, pwstrb_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0] eligible;
  logic               gnt;
  logic               gnt_vld;

  // Masking with done stops a requester that has not yet seen its done pulse from being re-granted.
  assign eligible = req & ~done_q;

  apb_rr_pick2 u_pick (
    .eligible_i (eligible),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt),
    .gnt_vld_o  (gnt_vld)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwstrb_d    = pwstrb_q;
    done_d      = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d  = gnt;
          pwrite_d = req_write[gnt];
          paddr_d  = gnt ? req_addr1 : req_addr0;
          pwdata_d = gnt ? req_wdata1 : req_wdata0;
          pwstrb_d = req_write[gnt] ? (gnt ? req_wstrb1 : req_wstrb0) : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d     = pwrite_q ? '0 : prdata;
          rsp_err_d       = pslverr;
          done_d[owner_q] = 1'b1;
          last_gnt_d      = owner_q;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          state_d         = IDLE;
        end
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        else if (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d     = '0;
          rsp_err_d       = 1'b1;
          done_d[owner_q] = 1'b1;
          last_gnt_d      = owner_q;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwstrb_q    <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign done      = done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwstrb    = pwstrb_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter.
// Watchdog scenarios run only when APB_REQ_ARBITER_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

  logic        pclk;
  logic        preset_n;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [9:0]  req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [3:0]  req_wstrb0, req_wstrb1;
  logic [1:0]  done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;

  int checks = 0;
  int errors = 0;

  apb_req_arbiter #(
    .TIMEOUT_CYCLES (8),
    .TO_CNT_W       (4)
  ) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .req        (req),
    .req_write  (req_write),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_wstrb0 (req_wstrb0),
    .req_wstrb1 (req_wstrb1),
    .done       (done),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pwstrb     (pwstrb),
    .prdata     (prdata),
    .pslverr    (pslverr),
    .pready     (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    req = '0; req_write = '0;
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
    req_wstrb0 = '0; req_wstrb1 = '0;
    prdata = '0; pslverr = 1'b0; pready = 1'b0;
    repeat (3) step();
    checks++;
    if ({psel, penable, pwrite, paddr, pwstrb} !== 17'd0) begin
      errors++;
      $display("FAIL reset_ctrl: psel=%b penable=%b pwrite=%b paddr=%h pwstrb=%h, want all 0",
               psel, penable, pwrite, paddr, pwstrb);
    end
    checks++;
    if ({pwdata, done, rsp_rdata, rsp_err} !== 67'd0) begin
      errors++;
      $display("FAIL reset_rsp: pwdata=%h done=%b rsp_rdata=%h rsp_err=%b, want all 0",
               pwdata, done, rsp_rdata, rsp_err);
    end
    @(negedge pclk);
    preset_n = 1'b1;
    step();
  endtask

  task automatic test_contention();
    int n;
    int gnt_idx[4];
    int cyc[4];
    n = 0;
    req_write = 2'b00;
    req_addr0 = 10'h100;
    req_addr1 = 10'h200;
    prdata    = 32'h0000_0001;
    pready    = 1'b1;
    req       = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (psel && !penable) begin
        gnt_idx[n] = (paddr == 10'h200) ? 1 : 0;
        cyc[n]     = c;
        n++;
      end
    end
    req = 2'b00;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL contention_count: saw %0d grants, want 4", n);
    end
    checks++;
    if (cyc[0] !== 0) begin
      errors++;
      $display("FAIL contention_first: setup at cycle %0d, want 0", cyc[0]);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gnt_idx[i] !== (i % 2)) begin
        errors++;
        $display("FAIL contention_order[%0d]: granted %0d, want %0d", i, gnt_idx[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (cyc[i] - cyc[i-1] !== 3) begin
          errors++;
          $display("FAIL contention_gap[%0d]: spacing %0d cycles, want 3", i, cyc[i] - cyc[i-1]);
        end
      end
    end
    repeat (4) step();
    pready = 1'b0;
  endtask

  task automatic test_single_read();
    req_write  = 2'b00;
    req_addr0  = 10'h010;
    req_wstrb0 = 4'hF;
    req        = 2'b01;
    checks++;
    if (psel !== 1'b0) begin
      errors++;
      $display("FAIL read_n: psel=%b, want 0", psel);
    end
    step();
    checks++;
    if ({psel, penable, pwrite, paddr, pwstrb} !== {1'b1, 1'b0, 1'b0, 10'h010, 4'h0}) begin
      errors++;
      $display("FAIL read_setup: psel=%b penable=%b pwrite=%b paddr=%h pwstrb=%h, want 1 0 0 010 0",
               psel, penable, pwrite, paddr, pwstrb);
    end
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL read_access: psel=%b penable=%b, want 1 1", psel, penable);
    end
    step();
    checks++;
    if ({done, rsp_err, psel, penable} !== {2'b01, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_done: done=%b rsp_err=%b psel=%b penable=%b, want 01 0 0 0",
               done, rsp_err, psel, penable);
    end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_data: rsp_rdata=%h, want deadbeef", rsp_rdata);
    end
    req    = 2'b00;
    pready = 1'b0;
    step();
    checks++;
    if ({done, psel} !== 3'b000) begin
      errors++;
      $display("FAIL read_after: done=%b psel=%b, want 00 0", done, psel);
    end
  endtask

  task automatic test_wait_error();
    req_write  = 2'b10;
    req_addr1  = 10'h3FF;
    req_wdata1 = 32'h1234_5678;
    req_wstrb1 = 4'b0011;
    prdata     = 32'hAAAA_5555;
    req        = 2'b10;
    step();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pwstrb} !==
        {1'b1, 1'b0, 1'b1, 10'h3FF, 32'h1234_5678, 4'b0011}) begin
      errors++;
      $display("FAIL wr_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pwstrb=%b",
               psel, penable, pwrite, paddr, pwdata, pwstrb);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, pwstrb, done} !==
          {1'b1, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678, 4'b0011, 2'b00}) begin
        errors++;
        $display("FAIL wr_hold[%0d]: psel=%b penable=%b paddr=%h pwdata=%h pwstrb=%b done=%b",
                 i, psel, penable, paddr, pwdata, pwstrb, done);
      end
      if (i == 1) req = 2'b00;
      if (i == 3) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
    end
    step();
    checks++;
    if ({done, rsp_err, rsp_rdata, psel} !== {2'b10, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wr_done: done=%b rsp_err=%b rsp_rdata=%h psel=%b, want 10 1 0 0",
               done, rsp_err, rsp_rdata, psel);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req_write = 2'b00;
    req_addr0 = 10'h0AB;
    req_addr1 = 10'h1CD;
    req       = 2'b01;
    step();
    step();
    step();
    checks++;
    if ({psel, penable, paddr} !== {1'b1, 1'b1, 10'h0AB}) begin
      errors++;
      $display("FAIL rstmid_access: psel=%b penable=%b paddr=%h, want 1 1 0ab", psel, penable, paddr);
    end
    #2;
    preset_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_drop: psel=%b penable=%b, want 0 0", psel, penable);
    end
    req = 2'b10;
    @(negedge pclk);
    checks++;
    if (done !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_nodone: done=%b, want 00", done);
    end
    preset_n = 1'b1;
    step();
    checks++;
    if ({psel, penable, paddr, done} !== {1'b1, 1'b0, 10'h1CD, 2'b00}) begin
      errors++;
      $display("FAIL rstmid_regrant: psel=%b penable=%b paddr=%h done=%b, want 1 0 1cd 00",
               psel, penable, paddr, done);
    end
    pready = 1'b1;
    step();
    step();
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_done1: done=%b, want 10", done);
    end
    req    = 2'b00;
    pready = 1'b0;
    step();
  endtask

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    acc = 0;
    req_write = 2'b00;
    req_addr0 = 10'h055;
    req_addr1 = 10'h066;
    prdata    = 32'h5555_AAAA;
    pready    = 1'b0;
    req       = 2'b11;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done != 2'b00) break;
      if (penable) acc++;
    end
    checks++;
    if (acc !== 8) begin
      errors++;
      $display("FAIL to_cycles: %0d ACCESS cycles before abort, want 8", acc);
    end
    checks++;
    if ({done, rsp_err, rsp_rdata, psel} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL to_abort: done=%b rsp_err=%b rsp_rdata=%h psel=%b, want 01 1 0 0",
               done, rsp_err, rsp_rdata, psel);
    end
    req = 2'b10;
    step();
    checks++;
    if ({psel, penable, paddr} !== {1'b1, 1'b0, 10'h066}) begin
      errors++;
      $display("FAIL to_next: psel=%b penable=%b paddr=%h, want 1 0 066", psel, penable, paddr);
    end
  endtask

  task automatic test_timeout_race();
    prdata  = 32'hCAFE_F00D;
    pslverr = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    checks++;
    if ({psel, penable, done} !== {1'b1, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL race_alive: psel=%b penable=%b done=%b, want 1 1 00", psel, penable, done);
    end
    pready = 1'b1;
    step();
    checks++;
    if ({done, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL race_done: done=%b rsp_err=%b rsp_rdata=%h, want 10 0 cafef00d",
               done, rsp_err, rsp_rdata);
    end
    req    = 2'b00;
    pready = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_wait_error();
    test_reset_mid();
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
